// File: rtl/pic_pkg.sv
// pic_pkg: shared types, constants and rotating-priority search for the PIC request front end
package pic_pkg;
  localparam int NUM_IR = 8;
  localparam logic [2:0] SPURIOUS_ID = 3'd7;
  typedef enum logic [2:0] {IDLE, ACK1, WAIT1, WAIT2, ACK2} state_t;
  typedef struct packed {
    logic       found;
    logic [2:0] id;
  } prio_t;
  function automatic prio_t prio_first(input logic [NUM_IR-1:0] bits, input logic [2:0] lowest_prio);
    prio_t r;
    logic [2:0] idx;
    r = '{found: 1'b0, id: 3'd0};
    for (int i = 0; i < NUM_IR; i++) begin
      idx = lowest_prio + 3'(i + 1);
      if (!r.found && bits[idx]) r = '{found: 1'b1, id: idx};
    end
    return r;
  endfunction
endpackage

// File: rtl/pic_irr_priority_if.sv
// pic_irr_priority_if: request pins, configuration and INTA/vector handshake of the PIC front end
interface pic_irr_priority_if;
  import pic_pkg::*;
  logic [NUM_IR-1:0] ir_in, interrupt_mask, in_service, irr, isr_set;
  logic              level_mode, rotate_en, inta_n, int_out, vector_valid;
  logic [4:0]        vector_base;
  logic [7:0]        vector_out;
  modport master (
    output ir_in, level_mode, interrupt_mask, in_service, rotate_en, vector_base, inta_n,
    input  int_out, irr, isr_set, vector_out, vector_valid
  );
  modport slave (
    input  ir_in, level_mode, interrupt_mask, in_service, rotate_en, vector_base, inta_n,
    output int_out, irr, isr_set, vector_out, vector_valid
  );
endinterface

// File: rtl/pic_priority_encoder.sv
// pic_priority_encoder: first set bit in rotating priority order starting after lowest_prio
module pic_priority_encoder
  import pic_pkg::*;
(
  input  logic [NUM_IR-1:0] bits,
  input  logic [2:0]        lowest_prio,
  output logic              found,
  output logic [2:0]        id
);
  prio_t r;
  assign r = prio_first(bits, lowest_prio);
  assign found = r.found;
  assign id = r.id;
endmodule

// File: rtl/pic_irr_priority.sv
// pic_irr_priority: IR synchronisation/latching, rotating priority resolution and two-pulse INTA handshake
module pic_irr_priority
  import pic_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input logic clk,
  input logic rst_n,
  pic_irr_priority_if.slave bus
);
  logic [SYNC_STAGES-1:0][NUM_IR-1:0] sync;
  logic [NUM_IR-1:0] ir_s, ir_prev, irr, cand, ack_take;
  logic [2:0] lowest_prio, sel, sel_rank, top, top_rank, ack_id;
  logic sel_found, top_found, ack_found, pending, inta_q, inta_fall, ack_evt, int_q;
  state_t state, state_nx;
  pic_priority_encoder u_sel (.bits(cand), .lowest_prio(lowest_prio), .found(sel_found), .id(sel));
  pic_priority_encoder u_top (.bits(bus.in_service), .lowest_prio(lowest_prio), .found(top_found), .id(top));
  assign ir_s = sync[SYNC_STAGES-1];
  assign cand = irr & ~bus.interrupt_mask;
  assign inta_fall = inta_q & ~bus.inta_n;
  assign ack_evt = (state == IDLE) && inta_fall;
  // rank 0 is the highest priority under the current rotation
  assign sel_rank = sel - lowest_prio - 3'd1;
  assign top_rank = top - lowest_prio - 3'd1;
  assign pending = sel_found && (!top_found || sel_rank < top_rank);
  assign ack_take = (ack_evt && sel_found) ? NUM_IR'(1) << sel : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
      ir_prev <= '0;
      irr <= '0;
      int_q <= 1'b0;
      inta_q <= 1'b1;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], bus.ir_in};
      ir_prev <= ir_s;
      irr <= (bus.level_mode ? ir_s : (irr | (ir_s & ~ir_prev)) & ir_s) & ~ack_take;
      int_q <= pending && state == IDLE && !inta_fall;
      inta_q <= bus.inta_n;
    end
  end
  // the acknowledged IR is frozen on the first INTA edge so later changes cannot alter it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lowest_prio <= 3'd7;
      ack_id <= SPURIOUS_ID;
      ack_found <= 1'b0;
    end else if (ack_evt) begin
      ack_found <= sel_found;
      ack_id <= sel_found ? sel : SPURIOUS_ID;
      if (bus.rotate_en && sel_found) lowest_prio <= sel;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  state_nx = inta_fall ? ACK1 : IDLE;
      ACK1:  state_nx = WAIT1;
      WAIT1: state_nx = bus.inta_n ? WAIT2 : WAIT1;
      WAIT2: state_nx = inta_fall ? ACK2 : WAIT2;
      ACK2:  state_nx = bus.inta_n ? IDLE : ACK2;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    bus.isr_set = (state == ACK1 && ack_found) ? NUM_IR'(1) << ack_id : '0;
    bus.vector_valid = state == ACK2;
    bus.vector_out = (state == ACK2) ? {bus.vector_base, ack_id} : '0;
  end
  assign bus.int_out = int_q;
  assign bus.irr = irr;
endmodule

// File: tb/tb_pic_irr_priority.sv
// tb_pic_irr_priority: directed and randomized checks against a rank-arithmetic reference model
module tb_pic_irr_priority;
  logic clk = 1'b0;
  logic rst_n;
  int checks = 0;
  int failures = 0;
  logic [7:0] m_pins = '0;
  logic [7:0] m_irr = '0;
  int m_low = 7;
  bit m_level = 0;
  pic_irr_priority_if bus ();
  pic_irr_priority #(.SYNC_STAGES(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int first_id(input logic [7:0] b, input int low);
    for (int r = 0; r < 8; r++) begin
      int id = (low + 1 + r) % 8;
      if (b[id]) return id;
    end
    return -1;
  endfunction
  function automatic int rank_of(input int id, input int low);
    return (id - low - 1 + 16) % 8;
  endfunction
  function automatic logic exp_pending(input logic [7:0] irr_v, input logic [7:0] mask, input logic [7:0] isv, input int low);
    logic [7:0] c = irr_v & ~mask;
    if (c == 0) return 1'b0;
    if (isv == 0) return 1'b1;
    return rank_of(first_id(c, low), low) < rank_of(first_id(isv, low), low);
  endfunction
  task automatic set_pins(input logic [7:0] p);
    m_irr = m_level ? p : ((m_irr & p) | (p & ~m_pins));
    m_pins = p;
    bus.ir_in = p;
    repeat (6) @(negedge clk);
  endtask
  task automatic check_state(input string tag);
    chk({tag, "_irr"}, bus.irr, m_irr);
    chk({tag, "_int"}, bus.int_out, exp_pending(m_irr, bus.interrupt_mask, bus.in_service, m_low));
  endtask
  task automatic handshake(input logic [7:0] exp_isr, input logic [7:0] exp_vec);
    bus.inta_n = 1'b0;
    @(negedge clk);
    chk("isr_set", bus.isr_set, exp_isr);
    chk("int_in_ack", bus.int_out, 0);
    chk("irr_ack1", bus.irr & exp_isr, 0);
    bus.inta_n = 1'b1;
    @(negedge clk);
    chk("isr_pulse", bus.isr_set, 0);
    @(negedge clk);
    bus.inta_n = 1'b0;
    @(negedge clk);
    chk("vec_valid", bus.vector_valid, 1);
    chk("vec_out", bus.vector_out, exp_vec);
    @(negedge clk);
    chk("vec_hold", bus.vector_out, exp_vec);
    bus.inta_n = 1'b1;
    @(negedge clk);
    chk("vec_done", bus.vector_valid, 0);
    if (exp_isr != 0) begin
      if (bus.rotate_en) m_low = int'(exp_vec[2:0]);
      m_irr &= ~exp_isr;
    end
    if (m_level) m_irr = m_pins;
    repeat (2) @(negedge clk);
    check_state("post_ack");
  endtask
  task automatic model_ack();
    logic [7:0] c = m_irr & ~bus.interrupt_mask;
    int id = first_id(c, m_low);
    logic [7:0] e_isr = (id >= 0) ? 8'(1) << id : 8'h00;
    logic [2:0] e_id = (id >= 0) ? 3'(id) : 3'd7;
    handshake(e_isr, {bus.vector_base, e_id});
  endtask
  initial begin
    rst_n = 1'b0;
    bus.ir_in = '0;
    bus.level_mode = 1'b0;
    bus.interrupt_mask = '0;
    bus.in_service = '0;
    bus.rotate_en = 1'b0;
    bus.vector_base = '0;
    bus.inta_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_int", bus.int_out, 0);
    chk("rst_irr", bus.irr, 0);
    chk("rst_isr", bus.isr_set, 0);
    chk("rst_vec", bus.vector_out, 0);
    chk("rst_valid", bus.vector_valid, 0);
    rst_n = 1'b1;
    @(negedge clk);
    bus.vector_base = 5'h01;
    bus.ir_in = 8'h08;
    m_pins = 8'h08;
    m_irr = 8'h08;
    repeat (3) @(negedge clk);
    chk("lat_3", bus.int_out, 0);
    @(negedge clk);
    chk("lat_4", bus.int_out, 1);
    chk("lat_irr", bus.irr, 8'h08);
    handshake(8'h08, 8'h0B);
    set_pins(8'h00);
    set_pins(8'h24);
    check_state("dual");
    handshake(8'h04, 8'h0A);
    bus.in_service = 8'h04;
    repeat (2) @(negedge clk);
    chk("dual_blocked", bus.int_out, 0);
    bus.in_service = 8'h00;
    repeat (2) @(negedge clk);
    chk("dual_second", bus.int_out, 1);
    handshake(8'h20, 8'h0D);
    set_pins(8'h00);
    bus.in_service = 8'h04;
    set_pins(8'h40);
    chk("isv_lower", bus.int_out, 0);
    set_pins(8'h42);
    chk("isv_higher", bus.int_out, 1);
    handshake(8'h02, 8'h09);
    bus.in_service = 8'h00;
    set_pins(8'h00);
    check_state("isv_clear");
    bus.rotate_en = 1'b1;
    set_pins(8'h10);
    handshake(8'h10, 8'h0C);
    set_pins(8'h00);
    set_pins(8'h28);
    handshake(8'h20, 8'h0D);
    bus.rotate_en = 1'b0;
    set_pins(8'h00);
    set_pins(8'h02);
    chk("spur_int", bus.int_out, 1);
    set_pins(8'h00);
    chk("spur_drop", bus.int_out, 0);
    handshake(8'h00, 8'h0F);
    m_level = 1;
    bus.level_mode = 1'b1;
    set_pins(8'h01);
    check_state("lvl");
    handshake(8'h01, 8'h08);
    chk("lvl_reraise", bus.int_out, 1);
    bus.inta_n = 1'b0;
    @(negedge clk);
    bus.inta_n = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_int", bus.int_out, 0);
    chk("mid_rst_irr", bus.irr, 0);
    chk("mid_rst_isr", bus.isr_set, 0);
    chk("mid_rst_vec", bus.vector_out, 0);
    chk("mid_rst_valid", bus.vector_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    m_low = 7;
    repeat (6) @(negedge clk);
    check_state("after_rst");
    handshake(8'h01, 8'h08);
    m_level = 0;
    bus.level_mode = 1'b0;
    set_pins(8'h00);
    for (int it = 0; it < 60; it++) begin
      if (it == 30) begin
        set_pins(8'h00);
        m_level = 1;
        bus.level_mode = 1'b1;
      end
      bus.interrupt_mask = 8'($urandom) & 8'($urandom);
      bus.in_service = ($urandom_range(0, 2) == 0) ? 8'(1) << $urandom_range(0, 7) : 8'h00;
      bus.rotate_en = 1'($urandom_range(0, 1));
      bus.vector_base = 5'($urandom);
      set_pins(8'($urandom));
      check_state("rnd");
      model_ack();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
